// File: rtl/pci_arb_pkg.sv
// Shared sizes and index/one-hot helpers for the PCI FIFO-mode arbiter back end.
package pci_arb_pkg;

    localparam int N_DEV = 8;
    localparam int ID_W  = 3;

    // Index is one bit wider than ID_W so that out-of-range values can be rejected.
    function automatic logic [N_DEV-1:0] id_to_onehot_n(input logic [ID_W:0] id);
        logic [N_DEV-1:0] res;
        res = '1;
        if (int'(id) < N_DEV) begin
            res[id[ID_W-1:0]] = 1'b0;
        end
        return res;
    endfunction

    function automatic logic [ID_W-1:0] lowest_set(input logic [N_DEV-1:0] vec);
        logic [ID_W-1:0] res;
        res = '0;
        for (int i = N_DEV - 1; i >= 0; i--) begin
            if (vec[i]) begin
                res = ID_W'(i);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/pci_id_fifo.sv
// Eight-entry ordering queue of device indices; head is read straight from storage.
module pci_id_fifo
    import pci_arb_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic [ID_W-1:0] push_id,
    input  logic            pop,
    output logic [ID_W-1:0] head,
    output logic [ID_W:0]   count
);

    localparam logic [ID_W:0] FULL = (ID_W + 1)'(N_DEV);

    logic [ID_W-1:0] mem [N_DEV];
    logic [ID_W-1:0] wr_ptr;
    logic [ID_W-1:0] rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign do_push = push && (count != FULL);
    assign do_pop  = pop && (count != '0);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_DEV; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_id;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pci_fifo_grant_decoder.sv
// FIFO-mode grant back end: queues requesting devices in arrival order, grants the head.
module pci_fifo_grant_decoder
    import pci_arb_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_DEV-1:0] req_n,
    input  logic             advance,
    output logic [N_DEV-1:0] gnt_n,
    output logic             gnt_valid,
    output logic [ID_W-1:0]  head_id,
    output logic [ID_W:0]    count
);

    logic [N_DEV-1:0] req_q;
    logic [N_DEV-1:0] queued;
    logic [N_DEV-1:0] queued_nxt;
    logic [N_DEV-1:0] candidate;
    logic [N_DEV-1:0] head_mask;
    logic [N_DEV-1:0] push_mask;
    logic [ID_W-1:0]  push_id;
    logic [ID_W-1:0]  fifo_head;
    logic             push;
    logic             pop;
    logic             not_empty;
    logic             head_withdrawn;

    pci_id_fifo u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .push_id (push_id),
        .pop     (pop),
        .head    (fifo_head),
        .count   (count)
    );

    assign not_empty      = (count != '0);
    assign head_id        = not_empty ? fifo_head : '0;
    assign head_mask      = ~id_to_onehot_n({1'b0, head_id});
    assign head_withdrawn = req_q[head_id];

    // A device already holding an entry is never a candidate, so the queue cannot overflow.
    assign candidate = ~req_q & ~queued;
    assign push      = |candidate;
    assign push_id   = lowest_set(candidate);
    assign push_mask = ~id_to_onehot_n({1'b0, push_id});
    assign pop       = not_empty && ((advance && gnt_valid) || head_withdrawn);

    always_comb begin
        queued_nxt = queued;
        if (pop) begin
            queued_nxt = queued_nxt & ~head_mask;
        end
        if (push) begin
            queued_nxt = queued_nxt | push_mask;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q     <= '1;
            queued    <= '0;
            gnt_n     <= '1;
            gnt_valid <= 1'b0;
        end else begin
            req_q  <= req_n;
            queued <= queued_nxt;
            // A head being popped this cycle is never granted, whatever the reason.
            if (not_empty && !pop) begin
                gnt_n     <= id_to_onehot_n({1'b0, head_id});
                gnt_valid <= 1'b1;
            end else begin
                gnt_n     <= '1;
                gnt_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pci_fifo_grant_decoder.sv
// Bench for pci_fifo_grant_decoder: expected grants queued at stimulus time, checked as grants appear.
module tb_pci_fifo_grant_decoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req_n;
    logic       advance;
    logic [7:0] gnt_n;
    logic       gnt_valid;
    logic [2:0] head_id;
    logic [3:0] count;

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0] exp_q [$];
    logic       prev_valid;

    pci_fifo_grant_decoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_n     (req_n),
        .advance   (advance),
        .gnt_n     (gnt_n),
        .gnt_valid (gnt_valid),
        .head_id   (head_id),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt(input string tag);
        for (int i = 0; i < 20 && !gnt_valid; i++) tick(1);
        chk(tag, 32'(gnt_valid), 32'h1);
    endtask

    task automatic consume(input int dev);
        req_n[dev] = 1'b1;
        advance    = 1'b1;
        tick(1);
        advance    = 1'b0;
    endtask

    // Grant monitor: every fresh grant must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid <= 1'b0;
        end else begin
            if (gnt_valid && !prev_valid) begin
                if (exp_q.size() == 0) chk("unexpected_grant", 32'(gnt_n), 32'hFF);
                else chk("grant", 32'(gnt_n), 32'(exp_q.pop_front()));
            end
            prev_valid <= gnt_valid;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        req_n   = 8'hFF;
        advance = 1'b0;
        tick(3);
        chk("rst_gnt_n", 32'(gnt_n), 32'hFF);
        chk("rst_gnt_valid", 32'(gnt_valid), 32'h0);
        chk("rst_count", 32'(count), 32'h0);
        chk("rst_head_id", 32'(head_id), 32'h0);
        rst_n = 1'b1;
        tick(2);

        // Single request from device 3
        req_n = 8'hF7;
        exp_q.push_back(8'hF7);
        tick(2);
        chk("single_count", 32'(count), 32'h1);
        chk("single_head", 32'(head_id), 32'h3);
        chk("single_nogrant_yet", 32'(gnt_valid), 32'h0);
        tick(1);
        chk("single_gnt", 32'(gnt_n), 32'hF7);
        consume(3);
        chk("single_pop_gnt", 32'(gnt_n), 32'hFF);
        chk("single_pop_count", 32'(count), 32'h0);
        tick(2);

        // Simultaneous requests: devices 1,3,4,6 queued in index order
        req_n = 8'hA5;
        exp_q.push_back(8'hFD);
        exp_q.push_back(8'hF7);
        exp_q.push_back(8'hEF);
        exp_q.push_back(8'hBF);
        tick(5);
        chk("simul_count", 32'(count), 32'h4);
        chk("simul_head", 32'(head_id), 32'h1);
        begin
            int devs [4] = '{1, 3, 4, 6};
            foreach (devs[k]) begin
                wait_gnt("simul_wait");
                consume(devs[k]);
            end
        end
        chk("simul_drained", 32'(count), 32'h0);
        tick(2);

        // Arrival order beats index order
        req_n[6] = 1'b0;
        exp_q.push_back(8'hBF);
        exp_q.push_back(8'hFB);
        tick(4);
        req_n[2] = 1'b0;
        wait_gnt("order_wait6");
        consume(6);
        wait_gnt("order_wait2");
        consume(2);
        chk("order_drained", 32'(count), 32'h0);
        tick(2);

        // Withdrawal of a queued non-head device
        req_n[0] = 1'b0;
        exp_q.push_back(8'hFE);
        tick(1);
        req_n[5] = 1'b0;
        tick(4);
        chk("wd_count2", 32'(count), 32'h2);
        chk("wd_gnt0", 32'(gnt_n), 32'hFE);
        req_n[5] = 1'b1;
        tick(3);
        chk("wd_still2", 32'(count), 32'h2);
        consume(0);
        chk("wd_after_adv_count", 32'(count), 32'h1);
        chk("wd_after_adv_valid", 32'(gnt_valid), 32'h0);
        tick(1);
        chk("wd_dropped_count", 32'(count), 32'h0);
        chk("wd_dropped_valid", 32'(gnt_valid), 32'h0);
        tick(3);
        chk("wd_never_granted", 32'(gnt_n), 32'hFF);

        // Full queue, then re-queue of device 0 at the tail
        req_n = 8'h00;
        exp_q.push_back(8'hFE);
        exp_q.push_back(8'hFD);
        tick(9);
        chk("full_count", 32'(count), 32'h8);
        chk("full_head", 32'(head_id), 32'h0);
        chk("full_gnt0", 32'(gnt_n), 32'hFE);
        advance = 1'b1;
        tick(1);
        advance = 1'b0;
        chk("full_adv_count", 32'(count), 32'h7);
        chk("full_adv_gnt", 32'(gnt_n), 32'hFF);
        tick(1);
        chk("full_requeue_count", 32'(count), 32'h8);
        chk("full_requeue_head", 32'(head_id), 32'h1);
        tick(1);
        chk("full_gnt1", 32'(gnt_n), 32'hFD);
        #2;
        rst_n = 1'b0;
        #1;
        chk("full_rst_count", 32'(count), 32'h0);
        req_n = 8'hFF;
        tick(2);
        rst_n = 1'b1;
        tick(2);

        // Asynchronous reset mid-grant with three entries queued
        req_n = 8'hF8;
        exp_q.push_back(8'hFE);
        tick(5);
        chk("rst3_count", 32'(count), 32'h3);
        chk("rst3_gnt", 32'(gnt_n), 32'hFE);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst3_gnt_n", 32'(gnt_n), 32'hFF);
        chk("rst3_gnt_valid", 32'(gnt_valid), 32'h0);
        chk("rst3_count0", 32'(count), 32'h0);
        chk("rst3_head0", 32'(head_id), 32'h0);
        req_n = 8'hFF;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(5);
        chk("post_rst_gnt_n", 32'(gnt_n), 32'hFF);
        chk("post_rst_count", 32'(count), 32'h0);

        chk("sb_drained", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
